// File: rtl/draw_pkg.sv
// Shared constants and types for the draw command scheduler.
package draw_pkg;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 3;

  // Command opcodes
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_POINT = 2'b01;
  localparam logic [1:0] OP_LINE  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  // Scheduler FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_POINT = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
    logic [3:0] color;
  } draw_cmd_t;

endpackage

// File: rtl/draw_cmd_fifo.sv
// 4-entry command FIFO. Flush clears everything and overrides push and pop.
module draw_cmd_fifo
  import draw_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  draw_cmd_t        wr_data,
  output draw_cmd_t        rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  draw_cmd_t     mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/draw_sched.sv
// Draw command scheduler: queues commands, starts the line/fill engines,
// and forwards the selected engine's pixel stream to the framebuffer port.
module draw_sched
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_x0,
  input  logic [7:0] cmd_y0,
  input  logic [7:0] cmd_x1,
  input  logic [7:0] cmd_y1,
  input  logic [3:0] cmd_color,
  input  logic       flush,
  output logic [7:0] eng_x0,
  output logic [7:0] eng_y0,
  output logic [7:0] eng_x1,
  output logic [7:0] eng_y1,
  output logic       line_start,
  output logic       fill_start,
  input  logic       line_done,
  input  logic       fill_done,
  input  logic [7:0] line_px,
  input  logic [7:0] line_py,
  input  logic [7:0] fill_px,
  input  logic [7:0] fill_py,
  input  logic       line_pv,
  input  logic       fill_pv,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic [3:0] pix_color,
  output logic       pix_we,
  output logic       sched_busy,
  output logic [2:0] cmd_count
);

  logic [1:0] state;
  draw_cmd_t  cur;
  draw_cmd_t  head;
  draw_cmd_t  in_cmd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       sel_line;
  logic       sel_pv;
  logic       sel_done;
  logic [7:0] sel_px;
  logic [7:0] sel_py;

  assign in_cmd    = '{op: cmd_op, x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, color: cmd_color};
  assign cmd_ready = !fifo_full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty && !flush;

  draw_cmd_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (in_cmd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (cmd_count)
  );

  // Only the engine owning the current command is listened to
  assign sel_line = (cur.op == OP_LINE);
  assign sel_pv   = sel_line ? line_pv   : fill_pv;
  assign sel_done = sel_line ? line_done : fill_done;
  assign sel_px   = sel_line ? line_px   : fill_px;
  assign sel_py   = sel_line ? line_py   : fill_py;

  assign line_start = (state == ST_ISSUE) && (cur.op == OP_LINE);
  assign fill_start = (state == ST_ISSUE) && (cur.op == OP_FILL);
  assign eng_x0     = cur.x0;
  assign eng_y0     = cur.y0;
  assign eng_x1     = cur.x1;
  assign eng_y1     = cur.y1;
  assign sched_busy = (state != ST_IDLE) || !fifo_empty;

  // Command sequencing FSM and current-command capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur <= head;
            case (head.op)
              OP_NOP:   state <= ST_IDLE;
              OP_POINT: state <= ST_POINT;
              default:  state <= ST_ISSUE;
            endcase
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT:  if (sel_done) state <= ST_IDLE;
        ST_POINT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Registered framebuffer write port; coordinates hold between writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_we    <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
    end else begin
      pix_we <= 1'b0;
      if (state == ST_WAIT && sel_pv) begin
        pix_we    <= 1'b1;
        pix_x     <= sel_px;
        pix_y     <= sel_py;
        pix_color <= cur.color;
      end else if (state == ST_POINT) begin
        pix_we    <= 1'b1;
        pix_x     <= cur.x0;
        pix_y     <= cur.y0;
        pix_color <= cur.color;
      end
    end
  end

endmodule

// File: tb/tb_draw_sched.sv
// Self-checking bench for draw_sched: queue-based reference model with
// per-cycle comparison, autonomous line/fill engine responders, and
// directed scenarios with literal pixel expectations.
module tb_draw_sched;

  localparam logic [1:0] NOP = 2'b00, PNT = 2'b01, LIN = 2'b10, FIL = 2'b11;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [3:0] cmd_color = '0;
  logic       flush = 1'b0;
  logic [7:0] eng_x0, eng_y0, eng_x1, eng_y1;
  logic       line_start, fill_start;
  logic       line_done = 1'b0, fill_done = 1'b0, line_pv = 1'b0, fill_pv = 1'b0;
  logic [7:0] line_px = '0, line_py = '0, fill_px = '0, fill_py = '0;
  logic [7:0] pix_x, pix_y;
  logic [3:0] pix_color;
  logic       pix_we, sched_busy;
  logic [2:0] cmd_count;

  always #5 clk = ~clk;

  draw_sched dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .flush(flush),
    .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_x1(eng_x1), .eng_y1(eng_y1),
    .line_start(line_start), .fill_start(fill_start),
    .line_done(line_done), .fill_done(fill_done),
    .line_px(line_px), .line_py(line_py), .fill_px(fill_px), .fill_py(fill_py),
    .line_pv(line_pv), .fill_pv(fill_pv),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_we(pix_we),
    .sched_busy(sched_busy), .cmd_count(cmd_count)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] op;
    logic [7:0] x0, y0, x1, y1;
    logic [3:0] c;
  } mcmd_t;

  mcmd_t      mq[$];
  mcmd_t      cur = '{op: 2'b00, x0: 8'h00, y0: 8'h00, x1: 8'h00, y1: 8'h00, c: 4'h0};
  int         phase = 0;  // 0 idle, 1 start pulse, 2 engine running, 3 point write
  logic       m_we = 1'b0;
  logic [7:0] m_x = '0, m_y = '0;
  logic [3:0] m_c = '0;
  bit         chk_on = 0;

  always @(posedge clk) begin
    mcmd_t      nc;
    bit         can_push, can_pop, pv, dn;
    logic [7:0] px, py;
    nc = '{op: cmd_op, x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, c: cmd_color};
    if (!rst_n) begin
      mq.delete();
      cur   = '{op: 2'b00, x0: 8'h00, y0: 8'h00, x1: 8'h00, y1: 8'h00, c: 4'h0};
      phase = 0;
      m_we  = 1'b0; m_x = '0; m_y = '0; m_c = '0;
    end else begin
      can_push = cmd_valid && (mq.size() < 4) && !flush;
      can_pop  = (phase == 0) && (mq.size() > 0) && !flush;
      m_we = 1'b0;
      case (phase)
        1: phase = 2;
        2: begin
          if (cur.op == LIN) begin pv = line_pv; dn = line_done; px = line_px; py = line_py; end
          else               begin pv = fill_pv; dn = fill_done; px = fill_px; py = fill_py; end
          if (pv) begin m_we = 1'b1; m_x = px; m_y = py; m_c = cur.c; end
          if (dn) phase = 0;
        end
        3: begin m_we = 1'b1; m_x = cur.x0; m_y = cur.y0; m_c = cur.c; phase = 0; end
        default: if (can_pop) begin
          cur = mq.pop_front();
          phase = (cur.op == NOP) ? 0 : (cur.op == PNT) ? 3 : 1;
        end
      endcase
      if (flush) mq.delete();
      else if (can_push) mq.push_back(nc);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmd_ready",  cmd_ready,  (mq.size() < 4) && !flush);
      chk("cmd_count",  cmd_count,  mq.size());
      chk("sched_busy", sched_busy, (phase != 0) || (mq.size() > 0));
      chk("line_start", line_start, (phase == 1) && (cur.op == LIN));
      chk("fill_start", fill_start, (phase == 1) && (cur.op == FIL));
      chk("pix_we",     pix_we,     m_we);
      chk("pix_x",      pix_x,      m_x);
      chk("pix_y",      pix_y,      m_y);
      chk("pix_color",  pix_color,  m_c);
      chk("eng_coords", {eng_x0, eng_y0, eng_x1, eng_y1}, {cur.x0, cur.y0, cur.x1, cur.y1});
    end
  end

  // ---------------- write log and pulse counters ----------------
  logic [7:0] wx[32], wy[32];
  logic [3:0] wc[32];
  int nw = 0, fs_cnt = 0, ls_cnt = 0;

  always @(negedge clk) begin
    if (pix_we === 1'b1 && nw < 32) begin
      wx[nw] = pix_x; wy[nw] = pix_y; wc[nw] = pix_color; nw++;
    end
    if (fill_start === 1'b1) fs_cnt++;
    if (line_start === 1'b1) ls_cnt++;
  end

  // ---------------- engine responders ----------------
  int   fill_gap = 0, line_gap = 0;
  bit   noise = 0, ntog = 0;
  bit   f_act = 0, l_act = 0;
  int   f_i = 0, f_n = 0, f_g = 0, l_i = 0, l_n = 0, l_g = 0;
  logic [7:0] fx[16], fy[16], lx[16], ly[16];

  // Latch the rectangle / horizontal span when a start pulse is seen
  always @(negedge clk) begin
    if (fill_start === 1'b1) begin
      f_n = 0; f_i = 0; f_g = fill_gap; f_act = 1;
      for (int y = int'(eng_y0); y <= int'(eng_y1); y++)
        for (int x = int'(eng_x0); x <= int'(eng_x1); x++)
          if (f_n < 16) begin fx[f_n] = 8'(x); fy[f_n] = 8'(y); f_n++; end
    end
    if (line_start === 1'b1) begin
      l_n = 0; l_i = 0; l_g = line_gap; l_act = 1;
      for (int x = int'(eng_x0); x <= int'(eng_x1); x++)
        if (l_n < 16) begin lx[l_n] = 8'(x); ly[l_n] = eng_y0; l_n++; end
    end
  end

  // Emit one pixel per cycle after the gap; done accompanies the last pixel
  always @(posedge clk) begin
    #2;
    fill_pv = 1'b0; fill_done = 1'b0; line_pv = 1'b0; line_done = 1'b0;
    if (f_act) begin
      if (f_g > 0) f_g--;
      else begin
        if (f_i < f_n) begin fill_pv = 1'b1; fill_px = fx[f_i]; fill_py = fy[f_i]; f_i++; end
        if (f_i >= f_n) begin fill_done = 1'b1; f_act = 0; end
      end
    end else if (noise) begin
      ntog = !ntog;
      fill_pv = ntog; fill_done = !ntog;
      fill_px = 8'($urandom); fill_py = 8'($urandom);
    end
    if (l_act) begin
      if (l_g > 0) l_g--;
      else begin
        if (l_i < l_n) begin line_pv = 1'b1; line_px = lx[l_i]; line_py = ly[l_i]; l_i++; end
        if (l_i >= l_n) begin line_done = 1'b1; l_act = 0; end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit saw_full = 0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] y0,
                      input logic [7:0] x1, input logic [7:0] y1, input logic [3:0] c);
    bit acc;
    int guard;
    acc = 0; guard = 0;
    cmd_valid = 1'b1; cmd_op = op;
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = c;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = cmd_ready;
      if (!acc) saw_full = 1;
      @(posedge clk); #2;
      guard++;
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done;
    done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (sched_busy === 1'b0) done = 1;
      @(posedge clk); #2;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [7:0] ex[5], ey[5];
    logic [3:0] ec[5];

    // Reset
    rst_n = 1'b0;
    tick(1);
    chk_on = 1;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_pix_we", pix_we, 0);
    chk("rst_pix_xyc", {pix_x, pix_y, pix_color}, 0);
    @(posedge clk); #2;

    // Single POINT
    nw = 0;
    push(PNT, 8'd5, 8'd7, 8'd0, 8'd0, 4'd3);
    wait_idle(20);
    tick(2);
    chk("point_nwrites", nw, 1);
    chk("point_pixel", {wx[0], wy[0], wc[0]}, {8'd5, 8'd7, 4'd3});
    chk("point_busy_clear", sched_busy, 0);

    // FILL 2x2 rectangle
    nw = 0; fs_cnt = 0; fill_gap = 0;
    push(FIL, 8'd2, 8'd2, 8'd3, 8'd3, 4'd9);
    wait_idle(40);
    tick(2);
    chk("fill_nwrites", nw, 4);
    chk("fill_start_pulses", fs_cnt, 1);
    ex[0] = 8'd2; ey[0] = 8'd2; ex[1] = 8'd3; ey[1] = 8'd2;
    ex[2] = 8'd2; ey[2] = 8'd3; ex[3] = 8'd3; ey[3] = 8'd3;
    for (int i = 0; i < 4; i++) chk("fill_pixel", {wx[i], wy[i], wc[i]}, {ex[i], ey[i], 4'd9});

    // LINE with fill-engine noise that must be ignored
    nw = 0; fs_cnt = 0; ls_cnt = 0; line_gap = 4; noise = 1;
    push(LIN, 8'd1, 8'd1, 8'd4, 8'd1, 4'd5);
    wait_idle(60);
    noise = 0; line_gap = 0;
    tick(2);
    chk("line_nwrites", nw, 4);
    chk("line_first", {wx[0], wy[0], wc[0]}, {8'd1, 8'd1, 4'd5});
    chk("line_last", {wx[3], wy[3], wc[3]}, {8'd4, 8'd1, 4'd5});
    chk("line_pulses", {ls_cnt[7:0], fs_cnt[7:0]}, {8'd1, 8'd0});

    // Back-to-back: FILL running, five more pushed, last one stalls on full
    nw = 0; fill_gap = 6; saw_full = 0;
    push(FIL, 8'd10, 8'd10, 8'd10, 8'd10, 4'd1);
    push(PNT, 8'd20, 8'd0, 8'd0, 8'd0, 4'd2);
    push(NOP, 8'd99, 8'd99, 8'd99, 8'd99, 4'd15);
    push(PNT, 8'd21, 8'd0, 8'd0, 8'd0, 4'd3);
    push(PNT, 8'd22, 8'd0, 8'd0, 8'd0, 4'd4);
    push(PNT, 8'd23, 8'd0, 8'd0, 8'd0, 4'd5);
    wait_idle(100);
    fill_gap = 0;
    tick(2);
    chk("b2b_saw_full", saw_full, 1);
    chk("b2b_nwrites", nw, 5);
    ex[0] = 8'd10; ex[1] = 8'd20; ex[2] = 8'd21; ex[3] = 8'd22; ex[4] = 8'd23;
    ec[0] = 4'd1;  ec[1] = 4'd2;  ec[2] = 4'd3;  ec[3] = 4'd4;  ec[4] = 4'd5;
    for (int i = 0; i < 5; i++) chk("b2b_order", {wx[i], wc[i]}, {ex[i], ec[i]});

    // Flush during first FILL's WAIT
    nw = 0; fs_cnt = 0; fill_gap = 3;
    push(FIL, 8'd30, 8'd30, 8'd30, 8'd30, 4'd6);
    push(FIL, 8'd31, 8'd31, 8'd31, 8'd31, 4'd7);
    push(FIL, 8'd32, 8'd32, 8'd32, 8'd32, 4'd8);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_count", cmd_count, 0);
    chk("flush_still_busy", sched_busy, 1);
    @(posedge clk); #2;
    wait_idle(40);
    fill_gap = 0;
    tick(2);
    chk("flush_nwrites", nw, 1);
    chk("flush_pixel", {wx[0], wy[0], wc[0]}, {8'd30, 8'd30, 4'd6});
    chk("flush_pulses", fs_cnt, 1);

    // Reset while waiting on the line engine
    nw = 0; line_gap = 8;
    push(LIN, 8'd40, 8'd40, 8'd42, 8'd40, 4'd2);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(15);
    line_gap = 0;
    chk("rstwait_nwrites", nw, 0);
    @(negedge clk);
    chk("rstwait_pix", {pix_we, pix_x, pix_y, pix_color}, 0);
    chk("rstwait_eng", {eng_x0, eng_y0, eng_x1, eng_y1}, 0);
    chk("rstwait_status", {sched_busy, cmd_count, line_start, fill_start}, 0);
    @(posedge clk); #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
